pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline stall/flush scheduler for the 5-stage core. Collects stall requests
//  from IF, ID, EX and MEM, and tracks multi-cycle EX ops (mult-acc, div) with a
//  countdown. Drives the per-stage hold vector consumed by pc_reg, if_id, id_ex,
//  ex_mem and mem_wb, plus flush/new_pc on exceptions. Keeps stall/flush perf counters.
// PARAMETERS
//  CNT_W    6   width of multi-cycle length/counter (max 2**CNT_W-1 extra cycles)
//  PERF_W   32  width of perf_stall_cnt (saturating)
//  FLUSH_W  16  width of perf_flush_cnt (saturating)
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       reset, synchronous, active-high
//  stallreq_if     in   1       fetch not ready (level)
//  stallreq_id     in   1       load-use hazard (level)
//  stallreq_mem    in   1       data memory not ready (level)
//  ex_mc_start     in   1       multi-cycle op present in EX this cycle (pulse)
//  ex_mc_cycles    in   CNT_W   extra cycles that op needs; sampled with ex_mc_start
//  excpt_valid     in   1       exception committed in MEM this cycle
//  excpt_pc        in   32      handler address for excpt_valid
//  stall           out  6       hold: [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb
//  flush           out  1       clear all pipeline registers this edge
//  new_pc          out  32      PC to load when flush=1, else 0
//  mc_busy         out  1       EX multi-cycle op still computing
//  mc_done         out  1       1-cycle pulse: EX result valid this cycle
//  perf_stall_cnt  out  PERF_W  cycles with stall[0]=1
//  perf_flush_cnt  out  FLUSH_W number of flushes
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=RUN, cnt=0, both perf counters=0. While rst=1,
//    all outputs are forced to 0 (stall, flush, new_pc, mc_busy, mc_done).
//  - stall, flush, new_pc, mc_busy and mc_done are combinational from the
//    registered state/cnt and the current inputs. No added latency.
//  - States: RUN, MC_WAIT. cnt is CNT_W wide.
//  - RUN:
//    - ex_mc_start=1 with N=ex_mc_cycles>0: EX stall is active this cycle
//      (mc_busy=1). Next state MC_WAIT with cnt<=N.
//    - N=0: start is ignored; no stall and no mc_done.
//  - MC_WAIT:
//    - cnt>1: EX stall active, mc_busy=1, cnt<=cnt-1.
//    - cnt==1: mc_done=1, no EX stall, next state RUN, cnt<=0.
//    - ex_mc_start is ignored in this state.
//    - Net effect: a start at T0 stalls T0..T0+N-1 and pulses mc_done at T0+N.
//    - cnt decrements regardless of other stall sources (the unit keeps computing).
//  - Priority, highest first:
//    1. excpt_valid: stall=0, flush=1, new_pc=excpt_pc.
//    2. stallreq_mem: stall=6'b011111.
//    3. EX stall: stall=6'b001111.
//    4. stallreq_id: stall=6'b000111.
//    5. stallreq_if: stall=6'b000011.
//    6. Otherwise: stall=0.
//  - Exception in MC_WAIT: flush wins, next state RUN, cnt<=0, mc_done suppressed
//    (the EX op is aborted).
//  - mc_done coinciding with stallreq_mem: mc_done still pulses once and the state
//    still returns to RUN. The EX unit must hold its result while ex_mem is stalled.
//  - Perf counters: perf_stall_cnt += 1 when stall[0]=1; perf_flush_cnt += 1 when
//    flush=1. Both saturate at all-ones and never wrap.
// STRUCTURE
//  - openmips_pkg (shared): stall_t (6-bit), constants STALL_NONE/IF/ID/EX/MEM,
//    typedef enum {RUN, MC_WAIT} pctrl_state_e.
//  - One sub-module: sat_counter #(W) (en, clr -> cnt), instantiated twice for the
//    perf counters.
//  - FSM, countdown and priority mux stay inline in pipe_ctrl.
// TESTING
//  1. Reset: hold rst=1 with all requests high -> all outputs 0.
//     After release -> perf counters read 0.
//  2. Priority: stallreq_if=1 only -> 000011; add stallreq_id -> 000111;
//     add stallreq_mem -> 011111; add excpt_valid with excpt_pc=32'h0000_0020
//     -> stall=0, flush=1, new_pc=32'h20.
//  3. Multi-cycle: ex_mc_start=1, ex_mc_cycles=3 at T0 -> stall=001111 at T0..T2;
//     mc_done=1 and stall=0 at T3; state RUN at T4.
//     ex_mc_cycles=0 -> no stall, no mc_done.
//  4. Abort: start with N=5, excpt_valid at T2 -> flush at T2; mc_done never asserted;
//     a new start at T3 with N=1 -> mc_done at T4.
//  5. Overlap: N=2 start with stallreq_mem=1 through T3 -> stall=011111 throughout;
//     mc_done pulses exactly once, at T2.
//  6. Saturation: preload perf counters via a force to all-ones minus 1, then apply
//     3 stall cycles -> counter stays at all-ones.

Source files
------------

// File: rtl/openmips_pkg.sv
// openmips_pkg: shared pipeline types and stall-vector encodings for the 5-stage core
//   stall_t        6-bit hold vector: [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb
//   STALL_*        hold patterns, each freezing its own stage and everything upstream
//   pctrl_state_e  pipe_ctrl FSM states
package openmips_pkg;
    typedef logic [5:0] stall_t;
    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_IF   = 6'b000011;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;
    localparam stall_t STALL_MEM  = 6'b011111;
    typedef enum logic {RUN, MC_WAIT} pctrl_state_e;
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping
//   clk  in   clock, rising edge
//   clr  in   synchronous clear, active-high
//   en   in   count this cycle
//   cnt  out  current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk)
        if (clr) cnt <= '0;
        else if (en && !(&cnt)) cnt <= cnt + W'(1);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush scheduler with multi-cycle EX tracking and perf counters
//   clk, rst          clock (rising edge), synchronous active-high reset
//   stallreq_if/id/mem  level stall requests from fetch, decode, memory
//   ex_mc_start       multi-cycle EX op present (pulse), ex_mc_cycles extra cycles it needs
//   excpt_valid       exception committed in MEM, excpt_pc handler address
//   stall             per-stage hold vector, flush / new_pc redirect on exception
//   mc_busy, mc_done  EX op still computing / result valid this cycle
//   perf_stall_cnt    saturating count of cycles with stall[0]=1
//   perf_flush_cnt    saturating count of flushes
module pipe_ctrl
    import openmips_pkg::*;
#(
    parameter int CNT_W   = 6,
    parameter int PERF_W  = 32,
    parameter int FLUSH_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_mem,
    input  logic               ex_mc_start,
    input  logic [CNT_W-1:0]   ex_mc_cycles,
    input  logic               excpt_valid,
    input  logic [31:0]        excpt_pc,
    output logic [5:0]         stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               mc_busy,
    output logic               mc_done,
    output logic [PERF_W-1:0]  perf_stall_cnt,
    output logic [FLUSH_W-1:0] perf_flush_cnt
);
    pctrl_state_e     state;
    logic [CNT_W-1:0] cnt;
    logic             mc_go;
    logic             ex_stall;
    logic             mc_last;

    // A zero-length start is ignored entirely; the countdown keeps running
    // underneath other stalls, only an exception aborts it.
    always_comb begin
        mc_go    = state == RUN && ex_mc_start && ex_mc_cycles != '0;
        ex_stall = mc_go || (state == MC_WAIT && cnt > CNT_W'(1));
        mc_last  = state == MC_WAIT && cnt == CNT_W'(1);
        flush    = !rst && excpt_valid;
        new_pc   = flush ? excpt_pc : 32'h0;
        mc_busy  = !rst && !excpt_valid && ex_stall;
        mc_done  = !rst && !excpt_valid && mc_last;
        stall    = (rst || excpt_valid) ? STALL_NONE :
                   stallreq_mem        ? STALL_MEM  :
                   ex_stall            ? STALL_EX   :
                   stallreq_id         ? STALL_ID   :
                   stallreq_if         ? STALL_IF   : STALL_NONE;
    end

    always_ff @(posedge clk)
        if (rst || excpt_valid) begin
            state <= RUN;
            cnt   <= '0;
        end else if (mc_go) begin
            state <= MC_WAIT;
            cnt   <= ex_mc_cycles;
        end else if (state == MC_WAIT) begin
            state <= mc_last ? RUN : MC_WAIT;
            cnt   <= mc_last ? '0 : cnt - CNT_W'(1);
        end

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .en  (stall[0]),
        .cnt (perf_stall_cnt)
    );

    sat_counter #(.W(FLUSH_W)) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .en  (flush),
        .cnt (perf_flush_cnt)
    );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_mem;
    logic        ex_mc_start;
    logic [5:0]  ex_mc_cycles;
    logic        excpt_valid;
    logic [31:0] excpt_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy, mc_done;
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if    (stallreq_if),
        .stallreq_id    (stallreq_id),
        .stallreq_mem   (stallreq_mem),
        .ex_mc_start    (ex_mc_start),
        .ex_mc_cycles   (ex_mc_cycles),
        .excpt_valid    (excpt_valid),
        .excpt_pc       (excpt_pc),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .mc_busy        (mc_busy),
        .mc_done        (mc_done),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs are checked 1 ns later.
    task automatic drive(input logic r, input logic i, input logic d, input logic m,
                         input logic s, input logic [5:0] n, input logic e, input logic [31:0] pc);
        @(negedge clk);
        rst = r; stallreq_if = i; stallreq_id = d; stallreq_mem = m;
        ex_mc_start = s; ex_mc_cycles = n; excpt_valid = e; excpt_pc = pc;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0);
    endtask

    initial begin
        // reset with every request asserted
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 1, 1, 1, 6'd3, 1, 32'hDEAD_BEEF);
            check("rst_stall", 32'(stall), 32'h0);
            check("rst_flush", 32'(flush), 32'h0);
            check("rst_new_pc", new_pc, 32'h0);
            check("rst_mc_busy", 32'(mc_busy), 32'h0);
            check("rst_mc_done", 32'(mc_done), 32'h0);
        end
        idle();
        check("rst_perf_stall", perf_stall_cnt, 32'h0);
        check("rst_perf_flush", 32'(perf_flush_cnt), 32'h0);

        // priority ladder
        drive(0, 1, 0, 0, 0, 6'd0, 0, 32'h0);
        check("prio_if", 32'(stall), 32'h03);
        drive(0, 1, 1, 0, 0, 6'd0, 0, 32'h0);
        check("prio_id", 32'(stall), 32'h07);
        drive(0, 1, 1, 1, 0, 6'd0, 0, 32'h0);
        check("prio_mem", 32'(stall), 32'h1F);
        check("prio_mem_flush", 32'(flush), 32'h0);
        drive(0, 1, 1, 1, 0, 6'd0, 1, 32'h0000_0020);
        check("prio_exc_stall", 32'(stall), 32'h0);
        check("prio_exc_flush", 32'(flush), 32'h1);
        check("prio_exc_pc", new_pc, 32'h20);
        idle();
        check("perf_stall_3", perf_stall_cnt, 32'd3);
        check("perf_flush_1", 32'(perf_flush_cnt), 32'd1);
        check("idle_new_pc", new_pc, 32'h0);

        // multi-cycle N=3, with an ignored restart while waiting
        drive(0, 0, 0, 0, 1, 6'd3, 0, 32'h0);
        check("mc_t0_stall", 32'(stall), 32'h0F);
        check("mc_t0_busy", 32'(mc_busy), 32'h1);
        drive(0, 0, 0, 0, 1, 6'd7, 0, 32'h0);
        check("mc_t1_stall", 32'(stall), 32'h0F);
        check("mc_t1_done", 32'(mc_done), 32'h0);
        drive(0, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        check("mc_t2_stall", 32'(stall), 32'h0F);
        check("mc_t2_done", 32'(mc_done), 32'h0);
        idle();
        check("mc_t3_done", 32'(mc_done), 32'h1);
        check("mc_t3_stall", 32'(stall), 32'h0);
        check("mc_t3_busy", 32'(mc_busy), 32'h0);
        idle();
        check("mc_t4_done", 32'(mc_done), 32'h0);
        check("mc_t4_stall", 32'(stall), 32'h0);

        // zero-length start is ignored
        drive(0, 0, 0, 0, 1, 6'd0, 0, 32'h0);
        check("mc0_stall", 32'(stall), 32'h0);
        check("mc0_busy", 32'(mc_busy), 32'h0);
        idle();
        check("mc0_done", 32'(mc_done), 32'h0);
        check("mc0_stall_next", 32'(stall), 32'h0);

        // abort a N=5 op at T2, then a fresh N=1 op
        drive(0, 0, 0, 0, 1, 6'd5, 0, 32'h0);
        check("abort_t0_stall", 32'(stall), 32'h0F);
        idle();
        check("abort_t1_stall", 32'(stall), 32'h0F);
        check("abort_t1_done", 32'(mc_done), 32'h0);
        drive(0, 0, 0, 0, 0, 6'd0, 1, 32'h0000_0100);
        check("abort_t2_flush", 32'(flush), 32'h1);
        check("abort_t2_stall", 32'(stall), 32'h0);
        check("abort_t2_pc", new_pc, 32'h100);
        check("abort_t2_done", 32'(mc_done), 32'h0);
        drive(0, 0, 0, 0, 1, 6'd1, 0, 32'h0);
        check("abort_t3_stall", 32'(stall), 32'h0F);
        check("abort_t3_done", 32'(mc_done), 32'h0);
        idle();
        check("abort_t4_done", 32'(mc_done), 32'h1);
        check("abort_t4_stall", 32'(stall), 32'h0);
        for (int k = 0; k < 4; k++) begin
            idle();
            check("abort_tail_done", 32'(mc_done), 32'h0);
        end

        // N=2 op overlapping a memory stall
        drive(0, 0, 0, 1, 1, 6'd2, 0, 32'h0);
        check("ovl_t0_stall", 32'(stall), 32'h1F);
        check("ovl_t0_done", 32'(mc_done), 32'h0);
        drive(0, 0, 0, 1, 0, 6'd0, 0, 32'h0);
        check("ovl_t1_stall", 32'(stall), 32'h1F);
        check("ovl_t1_done", 32'(mc_done), 32'h0);
        drive(0, 0, 0, 1, 0, 6'd0, 0, 32'h0);
        check("ovl_t2_stall", 32'(stall), 32'h1F);
        check("ovl_t2_done", 32'(mc_done), 32'h1);
        drive(0, 0, 0, 1, 0, 6'd0, 0, 32'h0);
        check("ovl_t3_stall", 32'(stall), 32'h1F);
        check("ovl_t3_done", 32'(mc_done), 32'h0);
        idle();
        check("ovl_t4_done", 32'(mc_done), 32'h0);
        check("ovl_t4_busy", 32'(mc_busy), 32'h0);

        // saturation of both perf counters
        @(negedge clk);
        force dut.u_stall_cnt.cnt = 32'hFFFF_FFFE;
        force dut.u_flush_cnt.cnt = 16'hFFFE;
        @(negedge clk);
        release dut.u_stall_cnt.cnt;
        release dut.u_flush_cnt.cnt;
        #1;
        check("sat_stall_pre", perf_stall_cnt, 32'hFFFF_FFFE);
        check("sat_flush_pre", 32'(perf_flush_cnt), 32'hFFFE);
        for (int k = 0; k < 3; k++) drive(0, 1, 0, 0, 0, 6'd0, 0, 32'h0);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 6'd0, 1, 32'h40);
        idle();
        check("sat_stall", perf_stall_cnt, 32'hFFFF_FFFF);
        check("sat_flush", 32'(perf_flush_cnt), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
